// File: rtl/pos_embed_add.sv
// Streaming positional-embedding adder: joins token and pos-embed word streams,
// adds lane-wise with per-operand shifts, rounds, saturates and emits one word per join.
module pos_embed_add #(
  parameter int TOUT  = 32,
  parameter int DW    = 8,
  parameter int CNT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     cfg_tokens,
  input  logic [CNT_W-1:0]     cfg_slices,
  input  logic [2:0]           cfg_tok_shl,
  input  logic [2:0]           cfg_pos_shl,
  input  logic [3:0]           cfg_out_shr,
  input  logic                 tok_valid,
  output logic                 tok_ready,
  input  logic [TOUT*DW-1:0]   tok_data,
  input  logic                 pos_valid,
  output logic                 pos_ready,
  input  logic [TOUT*DW-1:0]   pos_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TOUT*DW-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int W = TOUT * DW;
  localparam logic signed [17:0] SAT_MAX = 18'((1 << (DW - 1)) - 1);
  localparam logic signed [17:0] SAT_MIN = -SAT_MAX - 18'sd1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] tokens_reg, slices_reg;
  logic [CNT_W-1:0] tok_cnt_reg, slice_cnt_reg;
  logic [2:0]       tok_shl_reg, pos_shl_reg;
  logic [3:0]       out_shr_reg;
  logic             issued_last_reg;
  logic             out_valid_reg, out_last_reg;
  logic [W-1:0]     out_data_reg;
  logic [W-1:0]     sum_next;
  logic             fire, zero_cfg, tok_last, slice_last, start_run;

  // 18-bit signed intermediate comfortably holds the largest shifted sum plus rounding bias.
  function automatic logic [DW-1:0] lane_calc(input logic [DW-1:0] t, input logic [DW-1:0] p,
                                               input logic [2:0] ts, input logic [2:0] ps,
                                               input logic [3:0] shr);
    logic signed [17:0] t_ext, p_ext, s, r;
    t_ext = {{(18 - DW){t[DW-1]}}, t};
    p_ext = {{(18 - DW){p[DW-1]}}, p};
    s = (t_ext <<< ts) + (p_ext <<< ps);
    r = s;
    if (shr != 4'd0)
      r = (s + (18'sd1 <<< (shr - 4'd1))) >>> shr;
    if (r > SAT_MAX)
      r = SAT_MAX;
    else if (r < SAT_MIN)
      r = SAT_MIN;
    return r[DW-1:0];
  endfunction

  for (genvar gi = 0; gi < TOUT; gi++) begin : g_lane
    assign sum_next[DW*gi +: DW] = lane_calc(tok_data[DW*gi +: DW], pos_data[DW*gi +: DW],
                                             tok_shl_reg, pos_shl_reg, out_shr_reg);
  end

  assign zero_cfg   = (cfg_tokens == '0) || (cfg_slices == '0);
  assign start_run  = (state_reg == IDLE) && start;
  assign tok_last   = (tok_cnt_reg == tokens_reg - CNT_W'(1));
  assign slice_last = (slice_cnt_reg == slices_reg - CNT_W'(1));
  assign fire = (state_reg == RUN) && tok_valid && pos_valid &&
                (!out_valid_reg || out_ready) && !issued_last_reg;

  assign tok_ready = fire;
  assign pos_ready = fire;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);
    case (state_reg)
      IDLE:    if (start) state_next = zero_cfg ? DONE : RUN;
      RUN:     if (out_valid_reg && out_ready && out_last_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tokens_reg  <= '0;
      slices_reg  <= '0;
      tok_shl_reg <= '0;
      pos_shl_reg <= '0;
      out_shr_reg <= '0;
    end else if (start_run) begin
      tokens_reg  <= cfg_tokens;
      slices_reg  <= cfg_slices;
      tok_shl_reg <= cfg_tok_shl;
      pos_shl_reg <= cfg_pos_shl;
      out_shr_reg <= cfg_out_shr;
    end
  end

  // Once the final word is issued, no further beats may be joined this run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_cnt_reg     <= '0;
      slice_cnt_reg   <= '0;
      issued_last_reg <= 1'b0;
    end else if (start_run) begin
      tok_cnt_reg     <= '0;
      slice_cnt_reg   <= '0;
      issued_last_reg <= 1'b0;
    end else if (fire) begin
      if (tok_last) begin
        tok_cnt_reg   <= '0;
        slice_cnt_reg <= slice_cnt_reg + CNT_W'(1);
        if (slice_last) issued_last_reg <= 1'b1;
      end else begin
        tok_cnt_reg <= tok_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
    end else if (fire) begin
      out_valid_reg <= 1'b1;
      out_last_reg  <= tok_last && slice_last;
      out_data_reg  <= sum_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pos_embed_add.sv
// Randomized self-checking bench for pos_embed_add against an arithmetic
// reference model and an in-order scoreboard of expected result words.
module tb_pos_embed_add;

  localparam int TOUT  = 32;
  localparam int DW    = 8;
  localparam int CNT_W = 12;
  localparam int W     = TOUT * DW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cfg_tokens = '0;
  logic [CNT_W-1:0] cfg_slices = '0;
  logic [2:0]       cfg_tok_shl = '0;
  logic [2:0]       cfg_pos_shl = '0;
  logic [3:0]       cfg_out_shr = '0;
  logic             tok_valid = 1'b0;
  logic             tok_ready;
  logic [W-1:0]     tok_data = '0;
  logic             pos_valid = 1'b0;
  logic             pos_ready;
  logic [W-1:0]     pos_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           obs_q[$];
  int           tok_tab[4];
  int           pos_tab[4];

  pos_embed_add #(.TOUT(TOUT), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_tokens(cfg_tokens), .cfg_slices(cfg_slices),
    .cfg_tok_shl(cfg_tok_shl), .cfg_pos_shl(cfg_pos_shl), .cfg_out_shr(cfg_out_shr),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_data(pos_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: scale by powers of two, round half up with floor division, clamp.
  function automatic int ref_lane(input int t, input int p, input int ts, input int ps, input int sh);
    int s, d, n, r;
    s = t * (1 << ts) + p * (1 << ps);
    if (sh == 0) begin
      r = s;
    end else begin
      d = 1 << sh;
      n = s + d / 2;
      r = n / d;
      if ((n % d != 0) && (n < 0)) r = r - 1;
    end
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic logic [W-1:0] ref_word(input logic [W-1:0] tw, input logic [W-1:0] pw,
                                            input int ts, input int ps, input int sh);
    logic [W-1:0] w;
    int r;
    w = '0;
    for (int i = 0; i < TOUT; i++) begin
      r = ref_lane(int'($signed(tw[DW*i +: DW])), int'($signed(pw[DW*i +: DW])), ts, ps, sh);
      w[DW*i +: DW] = r[DW-1:0];
    end
    return w;
  endfunction

  function automatic logic [W-1:0] make_word(input int lo, input int hi, input int tabv, input bit use_tab);
    logic [W-1:0] w;
    int v;
    w = '0;
    for (int i = 0; i < TOUT; i++) begin
      v = use_tab ? tabv : lo + int'($urandom_range(hi - lo));
      w[DW*i +: DW] = v[DW-1:0];
    end
    return w;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    checks++; if (tok_ready !== 1'b0 || pos_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b want 00", tok_ready, pos_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    $display("test_reset: done");
  endtask

  // Drives one run and scoreboards every word; abort_at>0 returns mid-run after that many words.
  task automatic test_stream(input int tokens, input int slices, input int tshl, input int pshl,
                             input int shr, input int skew, input int rdy_pct, input int lo,
                             input int hi, input int tab_len, input int abort_at, input string name);
    int total, consumed, accepted, age, cyc, after_last, bubbles;
    bit need_new, seen_valid, prev_stall, prev_last;
    logic [W-1:0] prev_data, cur_tok, cur_pos;
    total = tokens * slices;
    consumed = 0; accepted = 0; age = 0; cyc = 0; after_last = 0; bubbles = 0;
    need_new = 1'b1; seen_valid = 1'b0; prev_stall = 1'b0; prev_last = 1'b0;
    prev_data = '0; cur_tok = '0; cur_pos = '0;
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    cfg_tokens = CNT_W'(tokens); cfg_slices = CNT_W'(slices);
    cfg_tok_shl = 3'(tshl); cfg_pos_shl = 3'(pshl); cfg_out_shr = 4'(shr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    forever begin
      if (need_new) begin
        if (tab_len > 0) begin
          cur_tok = make_word(0, 0, tok_tab[consumed % tab_len], 1'b1);
          cur_pos = make_word(0, 0, pos_tab[consumed % tab_len], 1'b1);
        end else begin
          cur_tok = make_word(lo, hi, 0, 1'b0);
          cur_pos = make_word(lo, hi, 0, 1'b0);
        end
        need_new = 1'b0;
        age = 0;
      end
      tok_valid = 1'b1;
      pos_valid = (age >= skew);
      tok_data  = cur_tok;
      pos_data  = cur_pos;
      out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (after_last == 2) begin
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s post_done got done=%b busy=%b want 0 0", name, done, busy); end
        break;
      end
      if (after_last == 1) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done_pulse got %b want 1", name, done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s valid_after_last got %b want 0", name, out_valid); end
        after_last = 2;
      end else begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s early_done at word %0d got 1 want 0", name, accepted); end
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          errors++; $display("FAIL %s stall_hold got v=%b d=%h want v=1 d=%h", name, out_valid, out_data, prev_data);
        end
      end
      checks++;
      if (tok_ready !== pos_ready || (tok_ready && !(tok_valid && pos_valid))) begin
        errors++; $display("FAIL %s join got tok_ready=%b pos_ready=%b with pos_valid=%b want joined", name, tok_ready, pos_ready, pos_valid);
      end
      if (seen_valid && !out_valid && after_last == 0) bubbles++;
      if (out_valid) seen_valid = 1'b1;
      if (tok_ready === 1'b1) begin
        checks++;
        if (consumed >= total) begin
          errors++; $display("FAIL %s extra_beat got consume %0d want at most %0d", name, consumed + 1, total);
        end
        exp_q.push_back(ref_word(cur_tok, cur_pos, tshl, pshl, shr));
        consumed++;
        need_new = 1'b1;
      end else begin
        age++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s unexpected_word got %h want none", name, out_data);
        end else if (out_data !== exp_q[0]) begin
          errors++; $display("FAIL %s data word %0d got %h want %h", name, accepted, out_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        checks++;
        if (out_last !== (accepted == total - 1)) begin
          errors++; $display("FAIL %s last word %0d got %b want %b", name, accepted, out_last, accepted == total - 1);
        end
        obs_q.push_back(int'($signed(out_data[DW-1:0])));
        accepted++;
        if (accepted == total) after_last = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (abort_at > 0 && accepted == abort_at) begin
        $display("%s: aborted after %0d words", name, accepted);
        return;
      end
      cyc++;
      if (cyc > 20000) begin
        checks++; errors++;
        $display("FAIL %s timeout got %0d words want %0d", name, accepted, total);
        break;
      end
      @(negedge clk);
    end
    tok_valid = 1'b0;
    pos_valid = 1'b0;
    checks++; if (accepted != total) begin errors++; $display("FAIL %s word_count got %0d want %0d", name, accepted, total); end
    if (rdy_pct == 100 && skew == 0) begin
      checks++; if (bubbles != 0) begin errors++; $display("FAIL %s bubbles got %0d want 0", name, bubbles); end
    end
    $display("%s: tokens=%0d slices=%0d words=%0d", name, tokens, slices, accepted);
  endtask

  task automatic test_saturation;
    tok_tab[0] = 100;  pos_tab[0] = 100;
    tok_tab[1] = -100; pos_tab[1] = -100;
    tok_tab[2] = 127;  pos_tab[2] = -128;
    test_stream(3, 1, 0, 0, 0, 0, 100, 0, 0, 3, 0, "saturation");
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL sat_count got %0d want 3", obs_q.size());
    end else if (obs_q[0] != 127 || obs_q[1] != -128 || obs_q[2] != -1) begin
      errors++; $display("FAIL sat_values got %0d %0d %0d want 127 -128 -1", obs_q[0], obs_q[1], obs_q[2]);
    end
  endtask

  task automatic test_rounding;
    tok_tab[0] = 3;  pos_tab[0] = 0;
    tok_tab[1] = -3; pos_tab[1] = 0;
    test_stream(2, 1, 0, 0, 1, 0, 100, 0, 0, 2, 0, "round_shr1");
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL round_count got %0d want 2", obs_q.size());
    end else if (obs_q[0] != 2 || obs_q[1] != -1) begin
      errors++; $display("FAIL round_values got %0d %0d want 2 -1", obs_q[0], obs_q[1]);
    end
    tok_tab[0] = 5; pos_tab[0] = 4;
    test_stream(1, 1, 2, 0, 2, 0, 100, 0, 0, 1, 0, "round_shl");
    checks++;
    if (obs_q.size() != 1 || obs_q[0] != 6) begin
      errors++; $display("FAIL round_shl got %0d want 6", (obs_q.size() != 0) ? obs_q[0] : -999);
    end
  endtask

  task automatic test_reset_midrun;
    test_stream(197, 6, 0, 0, 0, 0, 100, -50, 50, 0, 500, "reset_midrun");
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b%b want 00", out_valid, out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL midrst_data got %h want 0", out_data); end
    checks++; if (busy !== 1'b0 || tok_ready !== 1'b0) begin errors++; $display("FAIL midrst_busy_ready got %b%b want 00", busy, tok_ready); end
    tok_valid = 1'b0;
    pos_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_stream(2, 1, 0, 0, 0, 0, 100, -50, 50, 0, 0, "after_reset");
  endtask

  task automatic test_zero_config;
    int pulses, first_at;
    for (int v = 0; v < 2; v++) begin
      pulses = 0;
      first_at = -1;
      @(negedge clk);
      cfg_tokens = (v == 0) ? CNT_W'(0) : CNT_W'(5);
      cfg_slices = (v == 0) ? CNT_W'(6) : CNT_W'(0);
      tok_valid = 1'b1; pos_valid = 1'b1; out_ready = 1'b1;
      start = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++; if (tok_ready !== 1'b0 || pos_ready !== 1'b0) begin errors++; $display("FAIL zero_cfg%0d ready at %0d got %b%b want 00", v, k, tok_ready, pos_ready); end
        if (done === 1'b1) begin
          pulses++;
          if (first_at < 0) first_at = k;
        end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL zero_cfg%0d done_pulses got %0d want 1", v, pulses); end
      checks++; if (first_at < 1 || first_at > 2) begin errors++; $display("FAIL zero_cfg%0d done_delay got %0d want 1..2", v, first_at); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_cfg%0d busy got %b want 0", v, busy); end
      tok_valid = 1'b0; pos_valid = 1'b0;
      $display("zero_config_%0d: done after %0d cycles", v, first_at);
    end
  endtask

  task automatic test_busy_start;
    int words;
    bit got_done;
    words = 0;
    got_done = 1'b0;
    @(negedge clk);
    cfg_tokens = CNT_W'(3); cfg_slices = CNT_W'(1);
    cfg_tok_shl = '0; cfg_pos_shl = '0; cfg_out_shr = '0;
    tok_data = make_word(-50, 50, 0, 1'b0);
    pos_data = make_word(-50, 50, 0, 1'b0);
    tok_valid = 1'b1; pos_valid = 1'b1; out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    cfg_tokens = CNT_W'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL busy_start state got busy=%b valid=%b want 1 1", busy, out_valid); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (out_valid === 1'b1) begin
        words++;
        checks++;
        if (out_last !== (words == 3)) begin errors++; $display("FAIL busy_start last word %0d got %b want %b", words, out_last, words == 3); end
      end
    end
    tok_valid = 1'b0; pos_valid = 1'b0;
    checks++; if (!got_done || words != 3) begin errors++; $display("FAIL busy_start words got %0d done=%b want 3 done=1", words, got_done); end
    @(negedge clk);
    $display("busy_start: words=%0d", words);
  endtask

  task automatic test_random_shifts;
    for (int r = 0; r < 3; r++) begin
      test_stream(9, 3, int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(15)),
                  1, 70, -128, 127, 0, 0, "random_shifts");
    end
  endtask

  initial begin
    test_reset();
    test_stream(197, 6, 0, 0, 0, 0, 100, -50, 50, 0, 0, "full_rate");
    test_saturation();
    test_rounding();
    test_stream(197, 6, 0, 0, 0, 3, 50, -50, 50, 0, 0, "skew_backpressure");
    test_reset_midrun();
    test_zero_config();
    test_busy_start();
    test_random_shifts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
